// File: rtl/shift_add_multiplier_pkg.sv
// rtl/shift_add_multiplier_pkg.sv - shared arithmetic state encodings and defaults
// Purpose: state encoding and default operand width shared by the sequential
// arithmetic blocks (multiplier and its companion divider).
package shift_add_multiplier_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 32;

endpackage

// File: rtl/shift_add_multiplier.sv
// rtl/shift_add_multiplier.sv - sequential shift-and-add W x W -> 2W multiplier
// Purpose: one partial product per clock; result valid WIDTH cycles after accept.
// Ports:
//   clk      rising-edge clock
//   reset    asynchronous active-low reset
//   start    request, sampled only when not busy
//   mcand    multiplicand, sampled with start
//   mplier   multiplier, sampled with start
//   product  2*WIDTH result register, updated only on the last iteration
//   busy     high while iterating
//   finished high from result-valid until the next accepted start
module shift_add_multiplier
  import shift_add_multiplier_pkg::*;
#(
  parameter int WIDTH  = DEFAULT_WIDTH,
  parameter bit SIGNED = 1'b0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   mcand,
  input  logic [WIDTH-1:0]   mplier,
  output logic [2*WIDTH-1:0] product,
  output logic               busy,
  output logic               finished
);

  localparam int CW = $clog2(WIDTH) + 1;

  state_t             state;
  state_t             state_nxt;
  logic [2*WIDTH:0]   acc;
  logic [WIDTH-1:0]   mcand_reg;
  logic               neg;
  logic [CW-1:0]      cnt;

  logic               accept;
  logic               last_iter;
  logic [WIDTH-1:0]   mcand_mag;
  logic [WIDTH-1:0]   mplier_mag;
  logic               neg_in;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH:0]   acc_shift;
  logic [2*WIDTH-1:0] product_nxt;

  assign accept    = start && (state != RUN);
  assign last_iter = (state == RUN) && (cnt == CW'(WIDTH - 1));
  assign busy      = (state == RUN);
  assign finished  = (state == DONE);

  // Signed mode works on magnitudes; -2^(W-1) negates to itself, which read
  // as unsigned is exactly its magnitude 2^(W-1).
  always_comb begin
    mcand_mag  = mcand;
    mplier_mag = mplier;
    neg_in     = 1'b0;
    if (SIGNED) begin
      mcand_mag  = mcand[WIDTH-1]  ? -mcand  : mcand;
      mplier_mag = mplier[WIDTH-1] ? -mplier : mplier;
      neg_in     = mcand[WIDTH-1] ^ mplier[WIDTH-1];
    end
  end

  // acc[2W] is always zero between iterations, so adding into acc[2W:W]
  // equals adding into acc[2W-1:W] with the carry landing in bit 2W.
  always_comb begin
    sum         = acc[0] ? (acc[2*WIDTH:WIDTH] + {1'b0, mcand_reg}) : acc[2*WIDTH:WIDTH];
    acc_shift   = {1'b0, sum, acc[WIDTH-1:1]};
    product_nxt = neg ? -acc_shift[2*WIDTH-1:0] : acc_shift[2*WIDTH-1:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last_iter) state_nxt = DONE;
      DONE:    if (start) state_nxt = RUN;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc       <= '0;
      mcand_reg <= '0;
      neg       <= 1'b0;
      cnt       <= '0;
      product   <= '0;
    end else if (accept) begin
      mcand_reg <= mcand_mag;
      neg       <= neg_in;
      acc       <= {{(WIDTH + 1){1'b0}}, mplier_mag};
      cnt       <= '0;
    end else if (state == RUN) begin
      acc <= acc_shift;
      cnt <= cnt + 1'b1;
      if (last_iter) begin
        product <= product_nxt;
      end
    end
  end

endmodule

// File: tb/tb_shift_add_multiplier.sv
// tb/tb_shift_add_multiplier.sv - self-checking bench for shift_add_multiplier
module tb_shift_add_multiplier;

  localparam int W = 32;

  logic          clk;
  logic          reset;
  logic          start_u, start_s;
  logic [W-1:0]  mcand_u, mplier_u, mcand_s, mplier_s;
  logic [2*W-1:0] product_u, product_s;
  logic          busy_u, busy_s, finished_u, finished_s;

  int n_tests;
  int n_fail;
  logic [2*W-1:0] exp_prev [2];

  shift_add_multiplier #(.WIDTH(W), .SIGNED(1'b0)) dut_u (
    .clk(clk), .reset(reset), .start(start_u), .mcand(mcand_u), .mplier(mplier_u),
    .product(product_u), .busy(busy_u), .finished(finished_u)
  );

  shift_add_multiplier #(.WIDTH(W), .SIGNED(1'b1)) dut_s (
    .clk(clk), .reset(reset), .start(start_s), .mcand(mcand_s), .mplier(mplier_s),
    .product(product_s), .busy(busy_s), .finished(finished_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [2*W-1:0] got, input logic [2*W-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Plain integer arithmetic reference, truncated to 2W bits.
  function automatic logic [2*W-1:0] ref_mul(input bit sgn, input logic [W-1:0] a, input logic [W-1:0] b);
    longint sa, sb;
    if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      return 64'(sa * sb);
    end
    return {32'd0, a} * {32'd0, b};
  endfunction

  task automatic drive(input bit sel, input logic st, input logic [W-1:0] a, input logic [W-1:0] b);
    if (sel) begin
      start_s = st; mcand_s = a; mplier_s = b;
    end else begin
      start_u = st; mcand_u = a; mplier_u = b;
    end
  endtask

  function automatic logic [2*W-1:0] obs_prod(input bit sel);
    return sel ? product_s : product_u;
  endfunction

  function automatic logic obs_busy(input bit sel);
    return sel ? busy_s : busy_u;
  endfunction

  function automatic logic obs_fin(input bit sel);
    return sel ? finished_s : finished_u;
  endfunction

  // One operation: accept, optional start noise on cycles 5..10, then check
  // latency, result, and that product held its old value while running.
  task automatic do_op(input bit sel, input logic [W-1:0] a, input logic [W-1:0] b, input bit noise);
    logic [2*W-1:0] exp;
    int lat;
    int hold_err;
    exp = ref_mul(sel, a, b);
    @(negedge clk);
    drive(sel, 1'b1, a, b);
    @(posedge clk); #1;
    drive(sel, 1'b0, $urandom, $urandom);
    check("accept_busy", {63'd0, obs_busy(sel)}, 64'd1);
    check("accept_fin_low", {63'd0, obs_fin(sel)}, 64'd0);
    lat = 0;
    hold_err = 0;
    while (!obs_fin(sel) && lat < W + 4) begin
      if (noise && lat >= 4 && lat <= 9) drive(sel, 1'b1, $urandom, $urandom);
      else drive(sel, 1'b0, $urandom, $urandom);
      @(posedge clk); #1;
      lat++;
      if (!obs_fin(sel) && obs_prod(sel) !== exp_prev[sel]) hold_err++;
    end
    drive(sel, 1'b0, $urandom, $urandom);
    check("latency", 64'(lat), 64'(W));
    check("product", obs_prod(sel), exp);
    check("busy_clear", {63'd0, obs_busy(sel)}, 64'd0);
    check("hold_during_run", 64'(hold_err), 64'd0);
    exp_prev[sel] = exp;
  endtask

  initial begin
    logic [W-1:0] a, b, a2, b2;
    logic [2*W-1:0] e1, e2;
    int lat, low;
    n_tests = 0;
    n_fail  = 0;
    exp_prev[0] = '0;
    exp_prev[1] = '0;
    reset = 1'b0;
    drive(0, 1'b0, '0, '0);
    drive(1, 1'b0, '0, '0);
    repeat (3) @(posedge clk);
    #1;
    check("rst_prod_u", product_u, 64'd0);
    check("rst_busy_u", {63'd0, busy_u}, 64'd0);
    check("rst_fin_u", {63'd0, finished_u}, 64'd0);
    check("rst_prod_s", product_s, 64'd0);
    @(negedge clk);
    reset = 1'b1;

    do_op(0, 32'd7, 32'd2, 0);
    check("u_7x2", product_u, 64'd14);
    do_op(0, 32'hFFFFFFFF, 32'hFFFFFFFF, 0);
    check("u_max", product_u, 64'hFFFFFFFE_00000001);
    do_op(1, -32'sd7, 32'd2, 0);
    check("s_m7x2", product_s, 64'hFFFFFFFF_FFFFFFF2);
    do_op(1, 32'h80000000, 32'h80000000, 0);
    check("s_minsq", product_s, 64'h40000000_00000000);
    do_op(1, 32'd0, -32'sd5, 0);
    check("s_zero_neg", product_s, 64'd0);

    // start noise while busy must not disturb the running operation
    do_op(0, 32'd123456, 32'd789, 1);
    do_op(1, -32'sd1000, 32'd77, 1);

    // start held high: back-to-back acceptance
    a = $urandom; b = $urandom; a2 = $urandom; b2 = $urandom;
    e1 = ref_mul(0, a, b);
    e2 = ref_mul(0, a2, b2);
    @(negedge clk);
    drive(0, 1'b1, a, b);
    @(posedge clk); #1;
    drive(0, 1'b1, a2, b2);
    lat = 0;
    while (!finished_u && lat < W + 4) begin
      @(posedge clk); #1;
      lat++;
    end
    check("b2b_lat1", 64'(lat), 64'(W));
    check("b2b_prod1", product_u, e1);
    low = 0;
    while (low < W + 4) begin
      @(posedge clk); #1;
      if (finished_u) break;
      low++;
    end
    drive(0, 1'b0, $urandom, $urandom);
    check("b2b_fin_low_cycles", 64'(low), 64'(W));
    check("b2b_prod2", product_u, e2);
    exp_prev[0] = e2;

    // random traffic on both instances, plus divider round-trip
    for (int i = 0; i < 10; i++) begin
      do_op(0, $urandom, $urandom, bit'(i[0]));
      a = $urandom; b = $urandom;
      if (i == 3) a = 32'h80000000;
      if (i == 5) b = 32'd0;
      do_op(1, a, b, bit'(i[1]));
    end
    for (int i = 0; i < 8; i++) begin
      a = $urandom; b = $urandom;
      if (a == 0) a = 1;
      if (i == 0) a = 32'd1;
      do_op(0, a, b, 0);
      check("div_quot", product_u / {32'd0, a}, {32'd0, b});
      check("div_rem", product_u % {32'd0, a}, 64'd0);
    end

    // asynchronous reset mid-operation
    do_op(1, -32'sd3, 32'd9, 0);
    @(negedge clk);
    drive(0, 1'b1, 32'd1000, 32'd1000);
    @(posedge clk); #1;
    drive(0, 1'b0, '0, '0);
    repeat (12) @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    check("amid_prod_u", product_u, 64'd0);
    check("amid_busy_u", {63'd0, busy_u}, 64'd0);
    check("amid_fin_u", {63'd0, finished_u}, 64'd0);
    check("amid_prod_s", product_s, 64'd0);
    check("amid_fin_s", {63'd0, finished_s}, 64'd0);
    exp_prev[0] = '0;
    exp_prev[1] = '0;
    @(negedge clk);
    reset = 1'b1;
    do_op(0, 32'd3, 32'd5, 0);
    check("post_rst_3x5", product_u, 64'd15);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
